// File: rtl/uart_rx_os.sv
// Oversampling UART receive engine: 5..8 data bits, optional parity, 1/2 stop bits, break hold-off.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions; the default build uses a single sample.
module uart_rx_os #(
  parameter int OSR         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       sticky_parity,
  input  logic       eps,
  input  logic       pen,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       rx,
  output logic       push,
  output logic [7:0] dout,
  output logic       pe,
  output logic       fe,
  output logic       bi,
  output logic       busy
);

  localparam int CW = $clog2(OSR);
  localparam logic [CW-1:0] CNT_LAST = CW'(OSR - 1);
  localparam logic [CW-1:0] CNT_DEC  = CW'(OSR / 2 + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRK_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   bit_val;

  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic          stop_idx_q;
  logic [7:0]    data_q;
  logic          par_bit_q;
  logic          stop_zero_q;
  logic          stop_one_q;

  logic [1:0] wls_q;
  logic       pen_q;
  logic       eps_q;
  logic       sticky_q;
  logic       stb_q;

  logic decide;
  logic bit_end;
  logic last_data;
  logic last_stop;
  logic start_ok;
  logic frame_done;
  logic exp_par;
  logic fe_now;
  logic bi_now;

  // rx resets to idle-high so leaving reset never looks like a start edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] CNT_PRE = CW'(OSR / 2 - 1);
  localparam logic [CW-1:0] CNT_MID = CW'(OSR / 2);

  logic [1:0] win_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= 2'b11;
    end else if (baud_pulse) begin
      if (cnt_q == CNT_PRE) win_q[0] <= rx_s;
      if (cnt_q == CNT_MID) win_q[1] <= rx_s;
    end
  end

  assign bit_val = (win_q[0] & win_q[1]) | (win_q[0] & rx_s) | (win_q[1] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  assign decide    = baud_pulse && (cnt_q == CNT_DEC);
  assign bit_end   = baud_pulse && (cnt_q == CNT_LAST);
  assign last_data = (bit_idx_q == ({1'b0, wls_q} + 3'd4));
  assign last_stop = (stop_idx_q == stb_q);

  // Status of the frame being closed, evaluated with the last stop bit's own decision
  assign exp_par = sticky_q ? ~eps_q : ((^data_q) ^ ~eps_q);
  assign fe_now  = stop_zero_q | ~bit_val;
  assign bi_now  = (data_q == 8'h00) && !par_bit_q && !stop_one_q && !bit_val;

  always_comb begin
    state_d    = state_q;
    start_ok   = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (baud_pulse && !rx_s) begin
          state_d  = S_START;
          start_ok = 1'b1;
        end
      end
      S_START: begin
        if (decide && bit_val) begin
          state_d = S_IDLE;
        end else if (bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end && last_data) begin
          state_d = pen_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (decide && last_stop) begin
          frame_done = 1'b1;
          state_d    = bi_now ? S_BRK_WAIT : S_IDLE;
        end
      end
      S_BRK_WAIT: begin
        if (baud_pulse && rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame datapath: LCR snapshot at the start edge, bit capture at decisions, status on push
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      data_q      <= '0;
      par_bit_q   <= 1'b0;
      stop_zero_q <= 1'b0;
      stop_one_q  <= 1'b0;
      wls_q       <= '0;
      pen_q       <= 1'b0;
      eps_q       <= 1'b0;
      sticky_q    <= 1'b0;
      stb_q       <= 1'b0;
      push        <= 1'b0;
      dout        <= '0;
      pe          <= 1'b0;
      fe          <= 1'b0;
      bi          <= 1'b0;
    end else begin
      push <= frame_done;
      if (start_ok) begin
        cnt_q       <= '0;
        bit_idx_q   <= '0;
        stop_idx_q  <= 1'b0;
        data_q      <= '0;
        par_bit_q   <= 1'b0;
        stop_zero_q <= 1'b0;
        stop_one_q  <= 1'b0;
        wls_q       <= wls;
        pen_q       <= pen;
        eps_q       <= eps;
        sticky_q    <= sticky_parity;
        stb_q       <= stb;
      end else if (baud_pulse && (state_q != S_IDLE) && (state_q != S_BRK_WAIT)) begin
        cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        if (decide) begin
          case (state_q)
            S_DATA:   data_q[bit_idx_q] <= bit_val;
            S_PARITY: par_bit_q <= bit_val;
            S_STOP: begin
              if (bit_val) stop_one_q <= 1'b1;
              else         stop_zero_q <= 1'b1;
            end
            default: ;
          endcase
        end
        if (bit_end) begin
          if (state_q == S_DATA) bit_idx_q <= bit_idx_q + 3'd1;
          if (state_q == S_STOP) stop_idx_q <= 1'b1;
        end
      end
      if (frame_done) begin
        dout <= data_q;
        pe   <= pen_q & (par_bit_q ^ exp_par);
        fe   <= fe_now;
        bi   <= bi_now;
      end
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: each rx "slot" lasts one baud tick (baud_pulse every 6 clk, OSR=16).
// Frames are built as slot waveforms; the DUT's start tick is slot 0, so bit i is decided at slot 16*i+10.
module tb_uart_rx_os;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_pulse = 1'b0;
  logic       sticky_parity;
  logic       eps;
  logic       pen;
  logic [1:0] wls;
  logic       stb;
  logic       rx;
  logic       push;
  logic [7:0] dout;
  logic       pe;
  logic       fe;
  logic       bi;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int div = 0;
  int push_count = 0;
  int push_cyc = 0;
  int dec_cyc = -1;

  logic wave [0:255];
  int   wave_len;
  int   last_dec;

  uart_rx_os dut (
    .clk          (clk),
    .rst          (rst),
    .baud_pulse   (baud_pulse),
    .sticky_parity(sticky_parity),
    .eps          (eps),
    .pen          (pen),
    .wls          (wls),
    .stb          (stb),
    .rx           (rx),
    .push         (push),
    .dout         (dout),
    .pe           (pe),
    .fe           (fe),
    .bi           (bi),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // baud strobe changes on the falling edge so it is stable at every rising edge
  always @(negedge clk) begin
    if (div == 5) begin
      div = 0;
      baud_pulse = 1'b1;
    end else begin
      div = div + 1;
      baud_pulse = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (push) begin
      push_count = push_count + 1;
      push_cyc = cyc;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic driveSlot(input logic v);
    rx = v;
    do @(posedge clk); while (!baud_pulse);
    #1;
  endtask

  task automatic driveIdle(input int n);
    for (int i = 0; i < n; i++) driveSlot(1'b1);
  endtask

  task automatic putBit(input logic v);
    for (int i = 0; i < 16; i++) begin
      wave[wave_len] = v;
      wave_len = wave_len + 1;
    end
  endtask

  task automatic buildFrame(input logic [7:0] data, input int nd, input logic has_par,
                            input logic par_bit, input int nstop, input logic stop2);
    int nbits;
    wave_len = 0;
    putBit(1'b0);
    for (int i = 0; i < nd; i++) putBit(data[i]);
    if (has_par) putBit(par_bit);
    putBit(1'b1);
    if (nstop == 2) putBit(stop2);
    nbits = 1 + nd + (has_par ? 1 : 0) + nstop;
    last_dec = 16 * (nbits - 1) + 10;
    for (int i = 0; i < 16; i++) begin
      wave[wave_len] = 1'b1;
      wave_len = wave_len + 1;
    end
  endtask

  task automatic applyStimulus(input int first, input int last, input bit poke);
    for (int k = first; k <= last; k++) begin
      driveSlot(wave[k]);
      if (k == last_dec) dec_cyc = cyc;
      if (poke && k == 30) begin
        wls = 2'b00;
        pen = 1'b0;
        eps = ~eps;
        stb = ~stb;
        sticky_parity = ~sticky_parity;
      end
    end
  endtask

  task automatic setLcr(input logic [1:0] w, input logic p, input logic e, input logic s, input logic sb);
    wls = w;
    pen = p;
    eps = e;
    sticky_parity = s;
    stb = sb;
  endtask

  task automatic checkFrame(input string tag, input int pc0, input logic [7:0] d,
                            input logic p, input logic f, input logic b);
    checkOutput({tag, "_pushes"}, 32'(push_count - pc0), 32'd1);
    checkOutput({tag, "_dout"}, 32'(dout), 32'(d));
    checkOutput({tag, "_pe"}, 32'(pe), 32'(p));
    checkOutput({tag, "_fe"}, 32'(fe), 32'(f));
    checkOutput({tag, "_bi"}, 32'(bi), 32'(b));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_push"}, 32'(push), 32'd0);
    checkOutput({tag, "_dout"}, 32'(dout), 32'd0);
    checkOutput({tag, "_pe"}, 32'(pe), 32'd0);
    checkOutput({tag, "_fe"}, 32'(fe), 32'd0);
    checkOutput({tag, "_bi"}, 32'(bi), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic glitchFrame(input string tag, input int g0, input int g1, input logic [7:0] exp);
    int pc0;
    buildFrame(8'hFF, 8, 1'b0, 1'b0, 1, 1'b1);
    wave[g0] = 1'b0;
    if (g1 >= 0) wave[g1] = 1'b0;
    pc0 = push_count;
    applyStimulus(0, wave_len - 1, 1'b0);
    checkFrame(tag, pc0, exp, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int pc0;
    logic [7:0] exp_g9;

    rst = 1'b1;
    rx = 1'b1;
    setLcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;
    driveIdle(4);

    $display("[TB] 8O1 0x45, LCR changed mid-frame");
    setLcr(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    buildFrame(8'h45, 8, 1'b1, 1'b0, 1, 1'b1);
    pc0 = push_count;
    applyStimulus(0, wave_len - 1, 1'b1);
    checkFrame("t1", pc0, 8'h45, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_latency", 32'(push_cyc), 32'(dec_cyc));
    checkOutput("t1_busy_after", 32'(busy), 32'd0);

    $display("[TB] even parity with wrong parity bit, then stick parity");
    setLcr(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    buildFrame(8'h45, 8, 1'b1, 1'b0, 1, 1'b1);
    pc0 = push_count;
    applyStimulus(0, wave_len - 1, 1'b0);
    checkFrame("t2_even", pc0, 8'h45, 1'b1, 1'b0, 1'b0);
    setLcr(2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    pc0 = push_count;
    applyStimulus(0, wave_len - 1, 1'b0);
    checkFrame("t2_stick", pc0, 8'h45, 1'b0, 1'b0, 1'b0);

    $display("[TB] 5N2 0x15 with bad second stop bit");
    setLcr(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    buildFrame(8'h15, 5, 1'b0, 1'b0, 2, 1'b0);
    pc0 = push_count;
    applyStimulus(0, wave_len - 1, 1'b0);
    checkFrame("t3", pc0, 8'h15, 1'b0, 1'b1, 1'b0);
    checkOutput("t3_busy_after", 32'(busy), 32'd0);

    $display("[TB] false start");
    setLcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    pc0 = push_count;
    driveSlot(1'b0);
    checkOutput("t4_busy_start", 32'(busy), 32'd1);
    repeat (3) driveSlot(1'b0);
    driveIdle(16);
    checkOutput("t4_busy_false", 32'(busy), 32'd0);
    checkOutput("t4_no_push", 32'(push_count - pc0), 32'd0);

    $display("[TB] break on 8E1");
    setLcr(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    pc0 = push_count;
    repeat (192) driveSlot(1'b0);
    checkFrame("t4_brk", pc0, 8'h00, 1'b0, 1'b1, 1'b1);
    checkOutput("t4_brk_busy", 32'(busy), 32'd1);
    driveIdle(32);
    checkOutput("t4_brk_release", 32'(busy), 32'd0);
    checkOutput("t4_brk_pushes", 32'(push_count - pc0), 32'd1);
    buildFrame(8'h3C, 8, 1'b1, 1'b0, 1, 1'b1);
    pc0 = push_count;
    applyStimulus(0, wave_len - 1, 1'b0);
    checkFrame("t4_after", pc0, 8'h3C, 1'b0, 1'b0, 1'b0);

    $display("[TB] glitches in bit 3 of 0xFF");
    setLcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef UART_RX_MAJORITY_EN
    exp_g9 = 8'hFF;
`else
    exp_g9 = 8'hF7;
`endif
    glitchFrame("t5_cnt8", 73, -1, 8'hFF);
    glitchFrame("t5_cnt9", 74, -1, exp_g9);
    glitchFrame("t5_cnt89", 73, 74, 8'hF7);

    $display("[TB] reset during bit 4");
    buildFrame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
    pc0 = push_count;
    applyStimulus(0, 87, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkAllZero("t6_rst");
    driveIdle(200);
    checkOutput("t6_no_push", 32'(push_count - pc0), 32'd0);
    pc0 = push_count;
    applyStimulus(0, wave_len - 1, 1'b0);
    checkFrame("t6_after", pc0, 8'hA5, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
